// File: rtl/booth_multiplier_if.sv
// Handshake and operand/result bundle between the ALU control side and booth_multiplier.
// The master drives start and the operands; the slave (the multiplier) returns the product and status.
interface booth_multiplier_if #(
  parameter int WIDTH = 8
);
  logic                 start;
  logic [WIDTH-1:0]     multiplicand;
  logic [WIDTH-1:0]     multiplier;
  logic [2*WIDTH-1:0]   product;
  logic                 done;
  logic                 busy;
  logic                 ovf;

  modport master (
    output start, multiplicand, multiplier,
    input  product, done, busy, ovf
  );

  modport slave (
    input  start, multiplicand, multiplier,
    output product, done, busy, ovf
  );
endinterface

// File: rtl/booth_multiplier.sv
// Sequential radix-2 Booth multiplier: signed WIDTH x WIDTH -> 2*WIDTH, one Booth step per clock.
// Define BOOTH_OVF_EN to build the registered overflow flag; otherwise ovf is tied to 0.
module booth_multiplier #(
  parameter int WIDTH = 8
) (
  input  logic              clk,
  input  logic              reset,
  booth_multiplier_if.slave bus
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int PW = 2 * WIDTH;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nx;
  logic [WIDTH:0]   acc, acc_sum, acc_nx;
  logic [WIDTH-1:0] m_reg, q_reg, q_nx;
  logic             q_m1, q_m1_nx;
  logic [CW-1:0]    cnt;
  logic             accept, last_step;
  logic             busy_q, done_q;
  logic [PW-1:0]    product_q, product_fin;

  // done is asserted in the cycle after DONE; blocking accept there keeps a start
  // that coincides with the completion pulse from launching a new operation.
  assign accept      = (state == IDLE) && bus.start && !done_q;
  assign last_step   = (cnt == CW'(WIDTH - 1));
  assign product_fin = {acc[WIDTH-1:0], q_reg};

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept) state_nx = RUN;
      RUN:     if (last_step) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    acc_sum = acc;
    case ({q_reg[0], q_m1})
      2'b01:   acc_sum = acc + {m_reg[WIDTH-1], m_reg};
      2'b10:   acc_sum = acc - {m_reg[WIDTH-1], m_reg};
      default: acc_sum = acc;
    endcase
    {acc_nx, q_nx, q_m1_nx} = {acc_sum[WIDTH], acc_sum, q_reg};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      m_reg     <= '0;
      q_reg     <= '0;
      acc       <= '0;
      q_m1      <= 1'b0;
      cnt       <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      product_q <= '0;
    end else begin
      busy_q <= (state_nx == RUN);
      done_q <= (state == DONE);
      case (state)
        IDLE: begin
          if (accept) begin
            m_reg <= bus.multiplicand;
            q_reg <= bus.multiplier;
            acc   <= '0;
            q_m1  <= 1'b0;
            cnt   <= '0;
          end
        end
        RUN: begin
          acc   <= acc_nx;
          q_reg <= q_nx;
          q_m1  <= q_m1_nx;
          cnt   <= cnt + 1'b1;
        end
        DONE:    product_q <= product_fin;
        default: ;
      endcase
    end
  end

  assign bus.product = product_q;
  assign bus.done    = done_q;
  assign bus.busy    = busy_q;

`ifdef BOOTH_OVF_EN
  logic           ovf_q;
  logic [WIDTH:0] top_bits;

  // Representable as WIDTH-bit signed only if the upper WIDTH+1 bits are a pure sign extension.
  assign top_bits = product_fin[PW-1:WIDTH-1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset)              ovf_q <= 1'b0;
    else if (state == DONE) ovf_q <= !((&top_bits) || !(|top_bits));
  end

  assign bus.ovf = ovf_q;
`else
  assign bus.ovf = 1'b0;
`endif
endmodule

// File: tb/tb_booth_multiplier.sv
// Self-checking bench for booth_multiplier: cycle-exact op checks, scoreboard on done,
// ignored-start, reset-abort and a small ALU control-unit model driving start/booth_done.
module tb_booth_multiplier;
  localparam int WIDTH = 8;
  localparam int PW    = 2 * WIDTH;
`ifdef BOOTH_OVF_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif

  typedef struct {
    logic [PW-1:0] prod;
    logic          ovf;
  } exp_t;

  typedef struct {
    logic [WIDTH-1:0] m;
    logic [WIDTH-1:0] q;
    logic [PW-1:0]    p;
  } vec_t;

  typedef enum logic [1:0] {CU_IDLE, CU_WAIT_MUL, CU_DONE} cu_state_t;

  logic clk = 1'b0;
  logic reset;
  logic tb_start;
  logic cu_mode;
  logic alu_start;
  logic [3:0] op_code;
  logic booth_start;
  logic alu_done;
  cu_state_t cu_state;

  int total = 0;
  int bad = 0;
  int done_cnt = 0;
  int n_exp = 0;
  logic [PW-1:0] last_prod;
  exp_t sb[$];

  always #5 clk = ~clk;

  booth_multiplier_if #(.WIDTH(WIDTH)) bus ();

  booth_multiplier #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  assign bus.start = cu_mode ? booth_start : tb_start;

  // Minimal ALU control unit: op_code 10 launches the multiplier and waits in WAIT_MUL for booth_done.
  assign booth_start = (cu_state == CU_IDLE) && alu_start && (op_code == 4'd10);
  assign alu_done    = (cu_state == CU_DONE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cu_state <= CU_IDLE;
    else begin
      case (cu_state)
        CU_IDLE:     if (booth_start) cu_state <= CU_WAIT_MUL;
        CU_WAIT_MUL: if (bus.done) cu_state <= CU_DONE;
        default:     cu_state <= CU_IDLE;
      endcase
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic ovf_of(input int pi);
    return (pi > (2 ** (WIDTH - 1)) - 1) || (pi < -(2 ** (WIDTH - 1)));
  endfunction

  function automatic exp_t make_exp(input logic [WIDTH-1:0] m, input logic [WIDTH-1:0] q,
                                    input logic [PW-1:0] p);
    exp_t e;
    int mi, qi;
    mi = int'($signed(m));
    qi = int'($signed(q));
    e.prod = p;
    e.ovf  = OVF_EN ? ovf_of(mi * qi) : 1'b0;
    return e;
  endfunction

  function automatic logic [PW-1:0] ref_prod(input logic [WIDTH-1:0] m, input logic [WIDTH-1:0] q);
    logic [31:0] r;
    r = int'($signed(m)) * int'($signed(q));
    return r[PW-1:0];
  endfunction

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (bus.done === 1'b1) begin
      done_cnt++;
      if (sb.size() == 0) check("unexpected_done", 32'd1, 32'd0);
      else begin
        e = sb.pop_front();
        check("sb_product", bus.product, e.prod);
        check("sb_ovf", bus.ovf, e.ovf);
      end
    end
  end

  // Cycle-exact run; with inject, extra starts hit a RUN edge, the last step edge and the done cycle.
  task automatic run_op(input logic [WIDTH-1:0] m, input logic [WIDTH-1:0] q,
                        input logic [PW-1:0] exp_p, input bit inject);
    @(negedge clk);
    bus.multiplicand = m;
    bus.multiplier   = q;
    tb_start = 1'b1;
    sb.push_back(make_exp(m, q, exp_p));
    n_exp++;
    @(posedge clk); #1;
    check("busy_e0", bus.busy, 32'd1);
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      tb_start = inject && (k == 3 || k == 8 || k == 10);
      bus.multiplicand = tb_start ? 8'd5 : ~m;
      bus.multiplier   = tb_start ? 8'd5 : (q ^ 8'h5A);
      @(posedge clk); #1;
      check("busy", bus.busy, (k <= 7) ? 32'd1 : 32'd0);
      check("done", bus.done, (k == 9) ? 32'd1 : 32'd0);
      check("product_hold", bus.product, (k >= 9) ? exp_p : last_prod);
    end
    @(negedge clk);
    tb_start = 1'b0;
    last_prod = exp_p;
  endtask

  task automatic wait_done(input int budget);
    bit seen;
    int i;
    seen = 1'b0;
    i = 0;
    while (!seen && i < budget) begin
      @(posedge clk); #1;
      seen = (bus.done === 1'b1);
      i++;
    end
    check("wait_done", seen, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t vecs[6];
    int d0, d_at, a_at, a_cnt;
    logic [WIDTH-1:0] rm, rq;

    vecs = '{
      '{8'h07, 8'h03, 16'h0015},
      '{8'hFB, 8'h03, 16'hFFF1},
      '{8'h7F, 8'h80, 16'hC080},
      '{8'h80, 8'h80, 16'h4000},
      '{8'h10, 8'h08, 16'h0080},
      '{8'hF0, 8'h08, 16'hFF80}
    };

    reset = 1'b1;
    tb_start = 1'b0;
    cu_mode = 1'b0;
    alu_start = 1'b0;
    op_code = 4'd0;
    bus.multiplicand = '0;
    bus.multiplier = '0;
    last_prod = '0;
    #12;
    check("rst_product", bus.product, 32'd0);
    check("rst_busy", bus.busy, 32'd0);
    check("rst_done", bus.done, 32'd0);
    check("rst_ovf", bus.ovf, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    foreach (vecs[i]) run_op(vecs[i].m, vecs[i].q, vecs[i].p, 1'b0);

    run_op(8'h07, 8'h03, 16'h0015, 1'b1);
    run_op(8'h05, 8'h05, 16'h0019, 1'b0);

    // start held high for three IDLE/RUN edges must launch a single operation
    d0 = done_cnt;
    @(negedge clk);
    bus.multiplicand = 8'h03;
    bus.multiplier = 8'hFC;
    tb_start = 1'b1;
    sb.push_back(make_exp(8'h03, 8'hFC, 16'hFFF4));
    n_exp++;
    repeat (3) @(negedge clk);
    tb_start = 1'b0;
    wait_done(20);
    repeat (14) @(posedge clk);
    #1;
    check("held_start_once", done_cnt - d0, 32'd1);
    last_prod = 16'hFFF4;

    // asynchronous reset in the middle of an operation
    @(negedge clk);
    bus.multiplicand = 8'h09;
    bus.multiplier = 8'h09;
    tb_start = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    tb_start = 1'b0;
    repeat (4) @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    check("abort_product", bus.product, 32'd0);
    check("abort_busy", bus.busy, 32'd0);
    check("abort_done", bus.done, 32'd0);
    check("abort_ovf", bus.ovf, 32'd0);
    last_prod = '0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    d0 = done_cnt;
    repeat (14) @(posedge clk);
    #1;
    check("abort_no_done", done_cnt - d0, 32'd0);
    check("abort_idle_busy", bus.busy, 32'd0);

    run_op(8'h02, 8'hFD, 16'hFFFA, 1'b0);

    // control-unit integration: alu_done one cycle after done, product valid there
    @(negedge clk);
    cu_mode = 1'b1;
    op_code = 4'd10;
    bus.multiplicand = 8'h0C;
    bus.multiplier = 8'hF5;
    alu_start = 1'b1;
    sb.push_back(make_exp(8'h0C, 8'hF5, 16'hFF7C));
    n_exp++;
    d_at = -1;
    a_at = -1;
    a_cnt = 0;
    for (int k = 0; k < 16; k++) begin
      @(posedge clk); #1;
      if (bus.done === 1'b1) d_at = k;
      if (alu_done === 1'b1) begin
        a_at = k;
        a_cnt++;
        check("cu_product", bus.product, 32'h0000FF7C);
      end
      @(negedge clk);
      alu_start = 1'b0;
    end
    check("cu_done_at", d_at, 32'd9);
    check("cu_alu_done_at", a_at, 32'd10);
    check("cu_alu_done_once", a_cnt, 32'd1);
    cu_mode = 1'b0;
    last_prod = 16'hFF7C;

    for (int r = 0; r < 4; r++) begin
      rm = WIDTH'($urandom_range(0, 255));
      rq = WIDTH'($urandom_range(0, 255));
      run_op(rm, rq, ref_prod(rm, rq), 1'b0);
    end

    repeat (4) @(posedge clk);
    #1;
    check("sb_empty", sb.size(), 32'd0);
    check("done_total", done_cnt, n_exp);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
